uart_tx: RTL

Serial UART transmitter that serialises 8-bit bytes into framed asynchronous line data: start bit, 8 data bits MSB-first, optional even parity bit, and 1 or 2 stop bits. It is the transmit-side counterpart to the team's UART receive path, which shifts bits MSB-first and checks even parity. It sits between a byte-producing client, connected over a valid/ready handshake, and the serial line.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producing client and the UART transmitter.
// The client presents data_in with valid_in; the transmitter raises ready_out when it can take a byte.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB-first, optional even parity, 1 or 2 stop bits.
// A byte is accepted only in IDLE; the line is registered and idles high.
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx_out,
    output logic     busy_out,
    output logic     done_out
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic        stop_cnt;
    logic        bit_end;
    logic        ready;

    assign bit_end       = (baud_cnt == BAUD_LAST);
    assign ready         = (state == IDLE);
    assign bus.ready_out = ready;
    assign busy_out      = ~ready;

    // tx_out is loaded with the next bit's value on the edge that enters it, so the line
    // only ever moves on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            stop_cnt   <= 1'b0;
            tx_out     <= 1'b1;
            done_out   <= 1'b0;
        end else begin
            // NOTE: non-blocking default makes done_out a single-cycle pulse; later assignments in this block override it.
            done_out <= 1'b0;
            if (state != IDLE) baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        shift_reg  <= bus.data_in;
                        parity_bit <= ^bus.data_in;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        tx_out     <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_out <= shift_reg[7];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {shift_reg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7) begin
                            tx_out <= shift_reg[6];
                        end else if (PARITY_EN != 0) begin
                            tx_out <= parity_bit;
                            state  <= PARITY;
                        end else begin
                            tx_out   <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_out   <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            done_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
